// File: rtl/mips_alu_unit.sv
// ALU control decode, 32-bit ALU, PC+4 / branch-target adders and registered V/Z status flags.
// Optional feature: define ALU_OVF_EN to enable signed-overflow detection (otherwise overflow and v_flag are 0).
module mips_alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] imm_ext,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  output logic [2:0]  alu_ctl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic        v_flag,
  output logic        z_flag
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        v_flag_d, v_flag_q;
  logic        z_flag_d, z_flag_q;

  // Rules are applied in order; a later matching rule overrides an earlier one.
  always_comb begin
    // NOTE: default assigned first so every path drives alu_ctl and no latch is inferred.
    alu_ctl = 3'b010;
    if (!aluop1 && !aluop0)              alu_ctl = 3'b010;
    if (aluop0)                          alu_ctl = 3'b110;
    if (aluop1 && (funct == 4'b0000))    alu_ctl = 3'b010;
    if (aluop1 && funct[1] && funct[3])  alu_ctl = 3'b111;
    if (aluop1 && funct[1] && !funct[3]) alu_ctl = 3'b110;
    if (aluop1 && funct[2] && funct[0])  alu_ctl = 3'b001;
    if (aluop1 && funct[2] && !funct[0]) alu_ctl = 3'b000;
  end

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      3'b000:  alu_result = a & b;
      3'b001:  alu_result = a | b;
      3'b010:  alu_result = sum;
      3'b110:  alu_result = diff;
      // Signed compare directly, so the answer stays exact when a-b overflows.
      3'b111:  alu_result = {31'd0, ($signed(a) < $signed(b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

`ifdef ALU_OVF_EN
  always_comb begin
    overflow = 1'b0;
    if (alu_ctl == 3'b010)
      overflow = (a[31] == b[31]) && (sum[31] != a[31]);
    else if (alu_ctl == 3'b110)
      overflow = (a[31] != b[31]) && (diff[31] != a[31]);
  end
`else
  assign overflow = 1'b0;
`endif

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

  assign v_flag_d = overflow;
  assign z_flag_d = zero;

  // NOTE: non-blocking assignments for state so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      v_flag_q <= v_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

  assign v_flag = v_flag_q;
  assign z_flag = z_flag_q;

endmodule

// File: tb/tb_mips_alu_unit.sv
// Self-checking bench for mips_alu_unit: directed corner vectors plus $urandom stimulus
// compared against a behavioural model built from 64-bit signed arithmetic.
module tb_mips_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, a, b, imm_ext;
  logic        aluop1, aluop0;
  logic [3:0]  funct;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_result, pc_plus4, branch_target;
  logic        zero, overflow, v_flag, z_flag;

  int n_vec = 0;
  int n_err = 0;

`ifdef ALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_alu_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .a(a), .b(b), .imm_ext(imm_ext),
    .aluop1(aluop1), .aluop0(aluop0), .funct(funct), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .zero(zero), .overflow(overflow),
    .pc_plus4(pc_plus4), .branch_target(branch_target),
    .v_flag(v_flag), .z_flag(z_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Last-match-wins decode, evaluated from the highest-priority rule downwards.
  function automatic logic [2:0] ref_ctl(input logic op1, input logic op0, input logic [3:0] f);
    if (op1 && f[2] && !f[0]) return 3'b000;
    if (op1 && f[2] &&  f[0]) return 3'b001;
    if (op1 && f[1] && !f[3]) return 3'b110;
    if (op1 && f[1] &&  f[3]) return 3'b111;
    if (op1 && f == 4'b0000)  return 3'b010;
    if (op0)                  return 3'b110;
    return 3'b010;
  endfunction

  task automatic model(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output logic ovf);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 0;
    ovf = 1'b0;
    case (ctl)
      3'b000: r = longint'(x & y);
      3'b001: r = longint'(x | y);
      3'b010: begin r = sx + sy; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b110: begin r = sx - sy; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b111: r = (sx < sy) ? 1 : 0;
      default: r = 0;
    endcase
    res = r[31:0];
    ovf = ovf & OVF_ON;
  endtask

  task automatic drive(input logic op1, input logic op0, input logic [3:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] p, input logic [31:0] imm);
    aluop1 = op1; aluop0 = op0; funct = f;
    a = x; b = y; pc = p; imm_ext = imm;
    #1;
  endtask

  logic [2:0]  e_ctl;
  logic [31:0] e_res;
  logic        e_ovf;

  task automatic check_comb();
    e_ctl = ref_ctl(aluop1, aluop0, funct);
    model(e_ctl, a, b, e_res, e_ovf);
    check("alu_ctl", {29'd0, alu_ctl}, {29'd0, e_ctl});
    check("alu_result", alu_result, e_res);
    check("zero", {31'd0, zero}, {31'd0, (e_res == 32'd0)});
    check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
    check("pc_plus4", pc_plus4, pc + 32'd4);
    check("branch_target", branch_target, pc + 32'd4 + imm_ext * 32'd4);
  endtask

  // Clock once with the current inputs and check the flags captured from them.
  task automatic step_flags();
    logic xv, xz;
    e_ctl = ref_ctl(aluop1, aluop0, funct);
    model(e_ctl, a, b, e_res, e_ovf);
    xv = e_ovf;
    xz = (e_res == 32'd0);
    @(posedge clk);
    #1;
    check("v_flag", {31'd0, v_flag}, {31'd0, xv});
    check("z_flag", {31'd0, z_flag}, {31'd0, xz});
  endtask

  initial begin
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000; corners[1] = 32'h7FFF_FFFF; corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #11;
    check("reset_v", {31'd0, v_flag}, 32'd0);
    check("reset_z", {31'd0, z_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep
    drive(1'b0, 1'b0, 4'b1111, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_00", {29'd0, alu_ctl}, 32'd2);
    drive(1'b0, 1'b1, 4'b0100, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_01", {29'd0, alu_ctl}, 32'd6);
    drive(1'b1, 1'b0, 4'b0000, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_10_0000", {29'd0, alu_ctl}, 32'd2);
    drive(1'b1, 1'b0, 4'b0010, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_10_0010", {29'd0, alu_ctl}, 32'd6);
    drive(1'b1, 1'b0, 4'b0100, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_10_0100", {29'd0, alu_ctl}, 32'd0);
    drive(1'b1, 1'b0, 4'b0101, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_10_0101", {29'd0, alu_ctl}, 32'd1);
    drive(1'b1, 1'b0, 4'b1010, 32'd3, 32'd4, 32'd0, 32'd0);
    check("dec_10_1010", {29'd0, alu_ctl}, 32'd7);

    // Signed-overflow add
    drive(1'b0, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    check("add_ovf_res", alu_result, 32'h8000_0000);
    check("add_ovf_ovf", {31'd0, overflow}, {31'd0, OVF_ON});
    check("add_ovf_zero", {31'd0, zero}, 32'd0);
    step_flags();
    check("add_ovf_vflag", {31'd0, v_flag}, {31'd0, OVF_ON});

    // 5-5 subtract: zero result, z_flag after the edge
    drive(1'b0, 1'b1, 4'd0, 32'd5, 32'd5, 32'd0, 32'd0);
    check("sub_res", alu_result, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_ovf", {31'd0, overflow}, 32'd0);
    step_flags();
    check("sub_zflag", {31'd0, z_flag}, 32'd1);

    // Mid-cycle asynchronous reset
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_z", {31'd0, z_flag}, 32'd0);
    @(posedge clk);
    #1;
    check("held_rst_z", {31'd0, z_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_flags();
    check("post_rst_z", {31'd0, z_flag}, 32'd1);

    // slt corners
    drive(1'b1, 1'b0, 4'b1010, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
    check("slt_neg", alu_result, 32'd1);
    drive(1'b1, 1'b0, 4'b1010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    check("slt_pos", alu_result, 32'd0);
    check("slt_ovf", {31'd0, overflow}, 32'd0);

    // Adder wrap
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0);
    check("pc4_wrap", pc_plus4, 32'd0);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h0000_0010, 32'hFFFF_FFFF);
    check("bt_neg", branch_target, 32'h0000_0010);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h0000_1000, 32'hC000_0001);
    check("bt_drop_msbs", branch_target, 32'h0000_1008);

    // Randomised vectors, biased toward sign-boundary operands
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      drive(1'($urandom), 1'($urandom), 4'($urandom), ra, rb, $urandom, $urandom);
      check_comb();
      step_flags();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_alu_unit.md
# mips_alu_unit

Datapath arithmetic block for the single-cycle MIPS-lite processor: it decodes ALU operations, executes the 32-bit ALU operation, and computes PC+4 and the branch target. It also holds a two-bit status register (V, Z) that the `balrnv` / branch PC-select logic uses. It replaces the discrete ALU-control, ALU and adder instances in the processor datapath.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single system clock; status register samples on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pc` input 32: current program counter.
- `a` input 32: ALU operand A (register rs).
- `b` input 32: ALU operand B (register rt or sign-extended immediate, already muxed).
- `imm_ext` input 32: sign-extended 16-bit immediate (not shifted).
- `aluop1`, `aluop0` input 1 each: ALUOp from main control.
- `funct` input 4: instruction bits [3:0].
- `alu_ctl` output 3: decoded ALU control (gout).
- `alu_result` output 32: ALU result.
- `zero` output 1: alu_result == 0 (combinational).
- `overflow` output 1: signed overflow (combinational).
- `pc_plus4` output 32: pc + 4.
- `branch_target` output 32: pc_plus4 + (imm_ext << 2).
- `v_flag`, `z_flag` output 1 each: registered overflow and zero flags.

## Operation
ALU control decode, combinational, evaluated in priority order, last match wins:
- aluop1=0, aluop0=0: 010 (add).
- aluop0=1: 110 (sub).
- aluop1=1, funct=0000: 010.
- aluop1=1, funct[1]&funct[3]: 111 (slt).
- aluop1=1, funct[1]&~funct[3]: 110.
- aluop1=1, funct[2]&funct[0]: 001 (or).
- aluop1=1, funct[2]&~funct[0]: 000 (and).
- Any other case keeps the earlier assignment.
- Any case with no match yields 010.

ALU, combinational:
- 000: a & b.
- 001: a | b.
- 010: a + b, mod 2^32.
- 110: a − b, mod 2^32.
- 111: 1 if signed a < signed b, else 0. The comparison is exact, even when a−b overflows.
- 011, 100, 101: result 0.
- `zero` = (alu_result == 0) for every code.
- `overflow`:
  - add: a[31]==b[31] and result[31]!=a[31].
  - sub: a[31]!=b[31] and result[31]!=a[31].
  - all other codes: 0.

Adders:
- Both adders are 32-bit, wrap modulo 2^32, and have no carry out.
- Shift-left-2 discards imm_ext[31:30].

Status register:
- Every rising clk edge: v_flag<=overflow, z_flag<=zero. There is no enable.

## Timing
- All outputs except v_flag and z_flag are purely combinational (zero latency).
- v_flag/z_flag reflect the ALU state of the previous cycle (latency 1 clk).
- Reset: v_flag=0, z_flag=0 immediately on rst_n falling, independent of clk. Combinational outputs are unaffected by reset.
- rst_n is released synchronously to clk by the system. The first flag capture happens on the first rising edge with rst_n=1.
- Reset asserted mid-cycle clears flags at once. They stay 0 while rst_n=0.

## Configuration
- `ALU_OVF_EN` defined: overflow detection as specified; v_flag captures overflow.
- `ALU_OVF_EN` undefined: overflow tied to 0, v_flag constant 0. All other behaviour is unchanged.

## Test plan
- Decode sweep: aluop=00 -> 010; aluop=01 -> 110; aluop=10 with funct 0000/0010/0100/0101/1010 -> 010/110/000/001/111.
- Arithmetic: a=0x7FFFFFFF, b=1, add -> result 0x80000000, overflow=1, zero=0. a=5, b=5, sub -> result 0, zero=1, overflow=0.
- slt: a=0x80000000, b=1 -> 1. a=0x7FFFFFFF, b=0xFFFFFFFF -> 0, overflow=0.
- Adders: pc=0xFFFFFFFC -> pc_plus4=0. pc=0x10, imm_ext=0xFFFFFFFF -> branch_target=0x10.
- Flags: sub 5−5 on edge N -> z_flag=1 after edge N. Assert rst_n=0 mid-cycle -> z_flag=0 without a clock edge. With `ALU_OVF_EN` undefined, the 0x7FFFFFFF+1 add -> v_flag stays 0.
